tea_asme: RTL and testbench
===========================

TEA_ASME -- requirements
Module: tea_asme

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ena, input, 1 bit: clock enable; when low, all registers hold.
REQ-004 SHALL have port start, input, 1 bit: request encryption; sampled in IDLE only.
REQ-005 SHALL have port data, input, 64 bits: plaintext; v0=data[63:32], v1=data[31:0].
REQ-006 SHALL have port key, input, 48 bits: variable key part.
REQ-007 SHALL have port rdy, output, 1 bit: high in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high in ENC.
REQ-009 SHALL have port done, output, 1 bit: high in DONE only.
REQ-010 SHALL have port data_out, output, 64 bits: ciphertext {v0,v1}.
REQ-011 SHALL have port key_out, output, 48 bits: captured key register.

Function
REQ-012 SHALL implement states IDLE, ENC, DONE; transitions only on clk edges with ena=1.
REQ-013 SHALL, in IDLE with start=1, load v0/v1 from data, key register from key, sum=0, cnt=0, and enter ENC.
REQ-014 SHALL, in IDLE with start=0, hold all registers; data_out keeps its last ciphertext.
REQ-015 SHALL derive round keys as follows:
- k3 = byte-swapped key[31:0], i.e. {key[7:0],key[15:8],key[23:16],key[31:24]}.
- k2 = {key[39:32],key[47:40],16'h6874}.
- k1 = 32'h20736920.
- k0 = 32'h6B6C7568.
REQ-016 SHALL perform one round per enabled ENC cycle, in this order:
- sum' = sum+32'h9E3779B9.
- v0' = v0 + (((v1<<4)+k0) ^ (v1+sum') ^ ((v1>>5)+k1)).
- v1' = v1 + (((v0'<<4)+k2) ^ (v0'+sum') ^ ((v0'>>5)+k3)).
- cnt' = cnt+1.
REQ-017 SHALL perform all arithmetic modulo 2^32, with logical shifts.
REQ-018 SHALL leave ENC for DONE on the edge where cnt' reaches 32; sum then equals 32'hC6EF3720.
REQ-019 SHALL spend exactly one enabled cycle in DONE, then return to IDLE unconditionally.
REQ-020 SHALL have a latency of 34 enabled edges from the start-accept edge to rdy high again; done is high for exactly the 33rd–34th interval.
REQ-021 SHALL ignore start in ENC and DONE; no restart, no queueing.
REQ-022 SHALL make data_out bit-exact with the team's TEA decryptor: decrypting data_out with the same key returns the original data.
REQ-023 SHALL, with ena low in any state, freeze state, counters and outputs; the round count is unaffected by stall length.

Reset
REQ-024 SHALL, on rst high and independent of clk and ena, immediately force:
- state=IDLE.
- v0, v1, sum, key register = 0; cnt = 0.
- rdy=1, busy=0, done=0, data_out=0, key_out=0.
REQ-025 SHALL, on rst mid-ENC, discard the operation; after release, no done occurs without a new start.

Configuration
REQ-026 SHALL support macro TEA_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 with ena=1 in ENC or DONE returns to IDLE on the next edge, done is not asserted, and v0/v1/data_out are cleared to 0. abort has priority over round completion. abort in IDLE has priority over start: start is ignored.
- Undefined: no abort port; behaviour as REQ-012..REQ-023.

Verification
REQ-027 SHALL pass a round-trip test: key=48'h0123456789AB, data=64'h46445025_002E002D, start for one cycle, ena=1 -> done after 33 edges; feeding data_out and key to the decryptor yields its valid=1 and v=original data.
REQ-028 SHALL pass an ena stall test: same stimulus with ena toggled 1/0 every cycle -> data_out identical to REQ-027; done occurs at enabled edge 33 (about 66 clocks).
REQ-029 SHALL pass a start-while-busy test: pulse start again at ENC cycles 5 and 31 with different data -> single done, ciphertext of the first data only; rdy=0 throughout ENC and DONE.
REQ-030 SHALL pass a mid-operation reset test: assert rst at ENC cycle 10 -> outputs zero immediately, rdy=1; no done within 40 cycles after release without start.
REQ-031 SHALL pass a back-to-back test: start held high continuously -> new operation accepted on each IDLE cycle; done pulses every 34 enabled edges; key_out tracks each captured key.
REQ-032 SHALL pass an abort test (TEA_ABORT_EN): abort at ENC cycle 20 -> IDLE next edge, done never high, data_out=0.

Source files
------------

// File: rtl/tea_asme.sv
// tea_asme -- iterative TEA encryptor, one round per enabled clock.
//
// Ports:
//   clk       : clock; all state changes on its rising edge
//   rst       : asynchronous active-high reset
//   ena       : clock enable; when low every register holds
//   start     : encryption request, only looked at while in IDLE
//   data      : 64-bit plaintext, v0 = data[63:32], v1 = data[31:0]
//   key       : 48-bit variable key part, captured together with data
//   abort     : (only with TEA_ABORT_EN) cancel a running operation
//   rdy       : high in IDLE
//   busy      : high in ENC
//   done      : high in DONE only
//   data_out  : ciphertext {v0, v1}
//   key_out   : captured key register
//
// Handshake: start is a single-cycle request. It is accepted on an
// enabled edge while rdy is high. There is no queueing: a start seen
// while busy or done is simply dropped.
//
// Optional feature: define TEA_ABORT_EN to add the abort input.
module tea_asme (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        start,
  input  logic [63:0] data,
  input  logic [47:0] key,
`ifdef TEA_ABORT_EN
  input  logic        abort,
`endif
  output logic        rdy,
  output logic        busy,
  output logic        done,
  output logic [63:0] data_out,
  output logic [47:0] key_out
);

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [31:0] K0    = 32'h6B6C7568;
  localparam logic [31:0] K1    = 32'h20736920;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] v0_q, v0_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] sum_q, sum_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] key_q, key_d;

  logic        abort_w;
  logic [31:0] k2, k3;
  logic [31:0] sum_rnd, v0_rnd, v1_rnd;
  logic [5:0]  cnt_rnd;

`ifdef TEA_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Upper round keys come from the captured key; the lower two are fixed.
  assign k3 = {key_q[7:0], key_q[15:8], key_q[23:16], key_q[31:24]};
  assign k2 = {key_q[39:32], key_q[47:40], 16'h6874};

  // One full round; v1 uses the already-updated v0.
  always_comb begin
    sum_rnd = sum_q + DELTA;
    v0_rnd  = v0_q + (((v1_q << 4) + K0) ^ (v1_q + sum_rnd) ^ ((v1_q >> 5) + K1));
    v1_rnd  = v1_q + (((v0_rnd << 4) + k2) ^ (v0_rnd + sum_rnd) ^ ((v0_rnd >> 5) + k3));
    cnt_rnd = cnt_q + 6'd1;
  end

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          // abort outranks start in IDLE
          if (start && !abort_w) begin
            v0_d    = data[63:32];
            v1_d    = data[31:0];
            key_d   = key;
            sum_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = ENC;
          end
        end
        ENC: begin
          if (abort_w) begin
            v0_d    = 32'd0;
            v1_d    = 32'd0;
            sum_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = IDLE;
          end else begin
            v0_d  = v0_rnd;
            v1_d  = v1_rnd;
            sum_d = sum_rnd;
            cnt_d = cnt_rnd;
            if (cnt_rnd == 6'd32) state_d = DONE;
          end
        end
        DONE: begin
          if (abort_w) begin
            v0_d = 32'd0;
            v1_d = 32'd0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q    <= 32'd0;
      v1_q    <= 32'd0;
      sum_q   <= 32'd0;
      cnt_q   <= 6'd0;
      key_q   <= 48'd0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Status decodes straight from the state register so reset shows at once.
  assign rdy      = (state_q == IDLE);
  assign busy     = (state_q == ENC);
  assign done     = (state_q == DONE);
  assign data_out = {v0_q, v1_q};
  assign key_out  = key_q;

endmodule

// File: tb/tb_tea_asme.sv
// Testbench for tea_asme: table vectors, randomized operations with ena
// stalls, and hand-written multi-cycle corner cases.
module tb_tea_asme;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic [63:0] data;
  logic [47:0] key;
  logic        rdy, busy, done;
  logic [63:0] data_out;
  logic [47:0] key_out;
`ifdef TEA_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  tea_asme dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .start    (start),
    .data     (data),
    .key      (key),
`ifdef TEA_ABORT_EN
    .abort    (abort),
`endif
    .rdy      (rdy),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .key_out  (key_out)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [47:0] kexp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] round_keys(input logic [47:0] k);
    // {k3, k2, k1, k0}
    return {k[7:0], k[15:8], k[23:16], k[31:24],
            k[39:32], k[47:40], 16'h6874,
            32'h20736920, 32'h6B6C7568};
  endfunction

  function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [47:0] k);
    logic [127:0] rk;
    logic [31:0]  y, z, s;
    rk = round_keys(k);
    y  = d[63:32];
    z  = d[31:0];
    s  = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s += DELTA;
      y += ((z << 4) + rk[31:0])  ^ (z + s) ^ ((z >> 5) + rk[63:32]);
      z += ((y << 4) + rk[95:64]) ^ (y + s) ^ ((y >> 5) + rk[127:96]);
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [47:0] k);
    logic [127:0] rk;
    logic [31:0]  y, z, s;
    rk = round_keys(k);
    y  = c[63:32];
    z  = c[31:0];
    s  = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      z -= ((y << 4) + rk[95:64]) ^ (y + s) ^ ((y >> 5) + rk[127:96]);
      y -= ((z << 4) + rk[31:0])  ^ (z + s) ^ ((z >> 5) + rk[63:32]);
      s -= DELTA;
    end
    return {y, z};
  endfunction

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Accept edge counts as enabled edge 1. Returns the enabled-edge count
  // at which done was first seen (bounded by a clock budget).
  task automatic run_op(input logic [47:0] k, input logic [63:0] d, input int stall_mode,
                        output int edges, output bit seen_done, output bit flags_ok);
    @(negedge clk);
    key = k; data = d; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key   = rand48();
    data  = rand64();
    edges = 1; seen_done = 1'b0; flags_ok = 1'b1;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      case (stall_mode)
        0:       ena = 1'b1;
        1:       ena = ~ena;
        default: ena = ($urandom_range(0, 2) != 0);
      endcase
      @(posedge clk); #1;
      if (ena) edges++;
      if (done) seen_done = 1'b1;
      else if (rdy || !busy) flags_ok = 1'b0;
    end
  endtask

  // One enabled edge out of DONE; result must be held in IDLE.
  task automatic step_to_idle(input string name, input logic [63:0] ct);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk); #1;
    check({name, "_rdy_after"}, {62'd0, rdy, done}, 64'b10);
    check({name, "_hold"}, data_out, ct);
  endtask

  typedef struct {
    logic [47:0] key;
    logic [63:0] data;
    logic [63:0] exp_ct;
  } vec_t;

  vec_t        vt[5];
  int          edges;
  bit          seen, fl;
  logic [63:0] ct0, ct, exp;
  logic [47:0] k, kq;
  logic [63:0] d, d2;
  int          ndone;
  bit          bad;

  initial begin
    rst = 1'b1; ena = 1'b0; start = 1'b0; data = '0; key = '0;
`ifdef TEA_ABORT_EN
    abort = 1'b0;
`endif
    vt[0] = '{48'h0123456789AB, 64'h46445025_002E002D, 64'd0};
    vt[1] = '{48'h000000000000, 64'h00000000_00000000, 64'd0};
    vt[2] = '{48'hFFFFFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'd0};
    vt[3] = '{48'hA5A5A5A5A5A5, 64'h5A5A5A5A_A5A5A5A5, 64'd0};
    vt[4] = '{48'h800000000001, 64'h80000000_00000001, 64'd0};
    foreach (vt[i]) vt[i].exp_ct = tea_enc(vt[i].data, vt[i].key);

    // reset state
    #2;
    check("reset_flags", {61'd0, rdy, busy, done}, 64'b100);
    check("reset_data_out", data_out, 64'd0);
    check("reset_key_out", {16'd0, key_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors, ena held high
    foreach (vt[i]) begin
      run_op(vt[i].key, vt[i].data, 0, edges, seen, fl);
      check($sformatf("vec%0d_done_seen", i), 64'(seen), 64'd1);
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'd33);
      check($sformatf("vec%0d_ct", i), data_out, vt[i].exp_ct);
      check($sformatf("vec%0d_key_out", i), {16'd0, key_out}, {16'd0, vt[i].key});
      check($sformatf("vec%0d_roundtrip", i), tea_dec(data_out, key_out), vt[i].data);
      check($sformatf("vec%0d_busy_flags", i), 64'(fl), 64'd1);
      if (i == 0) ct0 = data_out;
      step_to_idle($sformatf("vec%0d", i), vt[i].exp_ct);
    end

    // ena toggling every cycle: same ciphertext, done at enabled edge 33
    run_op(vt[0].key, vt[0].data, 1, edges, seen, fl);
    check("stall_done_seen", 64'(seen), 64'd1);
    check("stall_latency", 64'(edges), 64'd33);
    check("stall_ct_same", data_out, ct0);
    step_to_idle("stall", ct0);

    // randomized operations with random stalls
    for (int r = 0; r < 6; r++) begin
      k = rand48(); d = rand64();
      exp_q.push_back(tea_enc(d, k));
      run_op(k, d, 2, edges, seen, fl);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_latency", r), 64'(edges), 64'd33);
      check($sformatf("rand%0d_ct", r), data_out, exp);
      check($sformatf("rand%0d_busy_flags", r), 64'(fl), 64'd1);
      step_to_idle($sformatf("rand%0d", r), exp);
    end

    // start while busy: pulses at ENC cycles 5 and 31 must be ignored
    k = rand48(); d = rand64(); d2 = ~d;
    @(negedge clk);
    key = k; data = d; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 1; ndone = 0; bad = 1'b0; ct = '0; kq = '0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      ena   = 1'b1;
      start = (edges == 5 || edges == 31);
      if (start) begin data = d2; key = ~k; end
      @(posedge clk); #1;
      edges++;
      if (done) begin ndone++; ct = data_out; kq = key_out; end
      if (edges <= 33 && rdy) bad = 1'b1;
    end
    start = 1'b0;
    check("busy_start_single_done", 64'(ndone), 64'd1);
    check("busy_start_ct", ct, tea_enc(d, k));
    check("busy_start_key", {16'd0, kq}, {16'd0, k});
    check("busy_start_rdy_low", 64'(bad), 64'd0);

    // reset in the middle of ENC
    k = rand48(); d = rand64();
    @(negedge clk);
    key = k; data = d; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 9; c++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_flags", {61'd0, rdy, busy, done}, 64'b100);
    check("midrst_data_out", data_out, 64'd0);
    check("midrst_key_out", {16'd0, key_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0; bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (!rdy) bad = 1'b1;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    check("midrst_rdy_stays", 64'(bad), 64'd0);

    // back-to-back with start held high; accepts at t = 0, 34, 68
    ndone = 0; bad = 1'b0;
    for (int t = 0; t < 102; t++) begin
      @(negedge clk);
      start = 1'b1; ena = 1'b1;
      key = rand48(); data = rand64();
      if (t % 34 == 0) begin
        exp_q.push_back(tea_enc(data, key));
        kexp_q.push_back(key);
      end
      @(posedge clk); #1;
      if (done !== (t % 34 == 32)) bad = 1'b1;
      if (done && exp_q.size() > 0) begin
        ndone++;
        check($sformatf("b2b%0d_ct", ndone), data_out, exp_q.pop_front());
        check($sformatf("b2b%0d_key_out", ndone), {16'd0, key_out}, {16'd0, kexp_q.pop_front()});
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_count", 64'(ndone), 64'd3);
    check("b2b_done_timing", 64'(bad), 64'd0);
    @(posedge clk); #1;
    check("b2b_idle_at_end", 64'(rdy), 64'd1);

`ifdef TEA_ABORT_EN
    // abort at ENC cycle 20
    k = rand48(); d = rand64();
    @(negedge clk);
    key = k; data = d; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 19; c++) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_flags", {61'd0, rdy, busy, done}, 64'b100);
    check("abort_data_out", data_out, 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    // abort beats start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_idle_blocks_start", {61'd0, rdy, busy, done}, 64'b100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
